rx_bit_timer: RTL and testbench

Receive-side bit-timing controller for the serial receive path.
- Tracks clock phase within each bit and emits a single-cycle shift_enable strobe at the configured sample point.
- Counts sampled bits and pulses byte_received after each complete byte.
- Realigns its phase to data edges via resync.
- Feeds the shift register and the receiver control FSM directly downstream.

---
 rtl/rx_bit_timer.sv | 121 ++++++++++++
 tb/tb_rx_bit_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: receive-side bit-timing controller.
//
// Tracks the clock phase inside each serial bit, strobes shift_enable at the
// configured sample point, counts sampled bits and pulses byte_received once
// per completed byte. resync realigns the bit phase to a detected data edge.
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   enable_timer  level, timing active while high
//   resync        pulse, data edge seen: restart the bit phase
//   clear         synchronous clear of all timing state
//   shift_enable  one-cycle sample strobe to the shift register
//   byte_received one-cycle pulse after the last bit of a byte
//   bit_cnt       bits sampled so far in the current byte
//   byte_cnt      bytes completed since leaving IDLE, saturates at 255
//   busy          high while in RUN
//
// state | meaning
// IDLE  | timing stopped, counters cleared (byte_cnt holds)
// RUN   | clk_cnt advancing, sampling bits
module rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             enable_timer,
    input  logic                             resync,
    input  logic                             clear,
    output logic                             shift_enable,
    output logic                             byte_received,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt,
    output logic [7:0]                       byte_cnt,
    output logic                             busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE   = CW'(SAMPLE_POINT);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_BYTE - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("rx_bit_timer: CLKS_PER_BIT must be >= 2");
        end
        if (SAMPLE_POINT >= CLKS_PER_BIT) begin : g_bad_sp
            $error("rx_bit_timer: SAMPLE_POINT must be < CLKS_PER_BIT");
        end
        if (BITS_PER_BYTE < 2) begin : g_bad_bpb
            $error("rx_bit_timer: BITS_PER_BYTE must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic          sample;

    // Decoded straight from registers so the strobe is glitch-free.
    assign sample       = (state == RUN) && (clk_cnt == SAMPLE);
    assign shift_enable = sample;
    assign busy         = (state == RUN);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            byte_received <= 1'b0;
        end else if (clear) begin
            // Also swallows a byte_received from a same-cycle final shift.
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            byte_received <= 1'b0;
        end else begin
            byte_received <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_timer) begin
                        state    <= RUN;
                        clk_cnt  <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                RUN: begin
                    // A sample coinciding with resync or enable dropping still counts.
                    if (sample) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt       <= '0;
                            byte_received <= 1'b1;
                            if (byte_cnt != 8'hFF)
                                byte_cnt <= byte_cnt + 8'd1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    if (resync || clk_cnt == CNT_LAST)
                        clk_cnt <= '0;
                    else
                        clk_cnt <= clk_cnt + CW'(1);
                    // Partial byte is discarded; byte_cnt holds until next entry.
                    if (!enable_timer) begin
                        state   <= IDLE;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Testbench for rx_bit_timer (default parameters). Cycle numbers count from
// the first cycle in RUN; outputs are sampled 1 time unit after each edge.
module tb_rx_bit_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable_timer;
    logic       resync;
    logic       clear;
    logic       shift_enable;
    logic       byte_received;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic       busy;

    rx_bit_timer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable_timer (enable_timer),
        .resync       (resync),
        .clear        (clear),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_cnt      (bit_cnt),
        .byte_cnt     (byte_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit chk;   // 1: compare expected outputs, 0: drive inputs
        bit en;
        bit rs;
        bit clr;
        bit se;
        bit br;
        int bc;
        int byc;
        bit bsy;
    } vec_t;

    vec_t sb[$];
    int   cyc;
    int   checks   = 0;
    int   failures = 0;
    int   br_seen  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic c(input int cy, input bit se, input bit br, input int bc,
                     input int byc, input bit bsy);
        vec_t v;
        v = '{cyc: cy, chk: 1'b1, en: 1'b0, rs: 1'b0, clr: 1'b0,
              se: se, br: br, bc: bc, byc: byc, bsy: bsy};
        sb.push_back(v);
    endtask

    task automatic d(input int cy, input bit en, input bit rs, input bit clr);
        vec_t v;
        v = '{cyc: cy, chk: 1'b0, en: en, rs: rs, clr: clr,
              se: 1'b0, br: 1'b0, bc: 0, byc: 0, bsy: 1'b0};
        sb.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (byte_received) br_seen++;
    endtask

    task automatic start_run();
        enable_timer = 1'b1;
        resync       = 1'b0;
        clear        = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        if (byte_received) br_seen++;
    endtask

    task automatic go_idle();
        enable_timer = 1'b0;
        resync       = 1'b0;
        clear        = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Walks cycles up to 'last', applying queued records as their cycle comes up.
    task automatic run_until(input int last);
        vec_t v;
        while (1) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                v = sb.pop_front();
                if (v.cyc < cyc) begin
                    check($sformatf("sb_order_c%0d", v.cyc), cyc, v.cyc);
                end else if (v.chk) begin
                    check($sformatf("c%0d.shift_enable", v.cyc), int'(shift_enable), int'(v.se));
                    check($sformatf("c%0d.byte_received", v.cyc), int'(byte_received), int'(v.br));
                    check($sformatf("c%0d.bit_cnt", v.cyc), int'(bit_cnt), v.bc);
                    check($sformatf("c%0d.byte_cnt", v.cyc), int'(byte_cnt), v.byc);
                    check($sformatf("c%0d.busy", v.cyc), int'(busy), int'(v.bsy));
                end else begin
                    enable_timer = v.en;
                    resync       = v.rs;
                    clear        = v.clr;
                end
            end
            if (cyc >= last) break;
            tick();
        end
        check("sb_leftover", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc          = 0;
        n_rst        = 1'b0;
        enable_timer = 1'b0;
        resync       = 1'b0;
        clear        = 1'b0;
        #22;
        check("rst.busy", int'(busy), 0);
        check("rst.shift_enable", int'(shift_enable), 0);
        check("rst.byte_received", int'(byte_received), 0);
        check("rst.bit_cnt", int'(bit_cnt), 0);
        check("rst.byte_cnt", int'(byte_cnt), 0);
        n_rst = 1'b1;
        tick();

        // Free-running: sample cadence and byte completion.
        start_run();
        c(0,   0, 0, 0, 0, 1);
        c(2,   0, 0, 0, 0, 1);
        c(3,   1, 0, 0, 0, 1);
        c(4,   0, 0, 1, 0, 1);
        c(11,  1, 0, 1, 0, 1);
        c(12,  0, 0, 2, 0, 1);
        c(59,  1, 0, 7, 0, 1);
        c(60,  0, 1, 0, 1, 1);
        c(61,  0, 0, 0, 1, 1);
        c(67,  1, 0, 0, 1, 1);
        c(123, 1, 0, 7, 1, 1);
        c(124, 0, 1, 0, 2, 1);
        c(125, 0, 0, 0, 2, 1);
        run_until(125);

        // resync realignment, resync on the final shift, held resync.
        go_idle();
        start_run();
        c(13, 0, 0, 2, 0, 1);
        d(13, 1, 1, 0);
        d(14, 1, 0, 0);
        c(14, 0, 0, 2, 0, 1);
        c(16, 0, 0, 2, 0, 1);
        c(17, 1, 0, 2, 0, 1);
        c(18, 0, 0, 3, 0, 1);
        c(19, 0, 0, 3, 0, 1);
        c(25, 1, 0, 3, 0, 1);
        c(57, 1, 0, 7, 0, 1);
        d(57, 1, 1, 0);
        d(58, 1, 0, 0);
        c(58, 0, 1, 0, 1, 1);
        c(60, 0, 0, 0, 1, 1);
        c(61, 1, 0, 0, 1, 1);
        d(62, 1, 1, 0);
        c(64, 0, 0, 1, 1, 1);
        c(66, 0, 0, 1, 1, 1);
        d(68, 1, 0, 0);
        c(70, 0, 0, 1, 1, 1);
        c(71, 1, 0, 1, 1, 1);
        c(72, 0, 0, 2, 1, 1);
        run_until(72);

        // enable drop mid-byte, re-entry, drop on final shift, resync in IDLE.
        go_idle();
        start_run();
        c(60,  0, 1, 0, 1, 1);
        c(104, 0, 0, 5, 1, 1);
        d(104, 0, 0, 0);
        c(105, 0, 0, 0, 1, 0);
        c(110, 0, 0, 0, 1, 0);
        d(110, 1, 0, 0);
        c(111, 0, 0, 0, 0, 1);
        c(113, 0, 0, 0, 0, 1);
        c(114, 1, 0, 0, 0, 1);
        c(170, 1, 0, 7, 0, 1);
        d(170, 0, 0, 0);
        c(171, 0, 1, 0, 1, 0);
        c(172, 0, 0, 0, 1, 0);
        d(172, 0, 1, 0);
        d(173, 0, 0, 0);
        c(174, 0, 0, 0, 1, 0);
        run_until(174);

        // clear on the final shift suppresses byte_received, then re-enters RUN.
        go_idle();
        start_run();
        c(59, 1, 0, 7, 0, 1);
        d(59, 1, 0, 1);
        d(60, 1, 0, 0);
        c(60, 0, 0, 0, 0, 0);
        c(61, 0, 0, 0, 0, 1);
        c(64, 1, 0, 0, 0, 1);
        run_until(64);

        // Asynchronous reset mid-RUN (clk_cnt=5).
        go_idle();
        start_run();
        c(69, 0, 0, 1, 1, 1);
        run_until(69);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst.busy", int'(busy), 0);
        check("arst.shift_enable", int'(shift_enable), 0);
        check("arst.byte_received", int'(byte_received), 0);
        check("arst.bit_cnt", int'(bit_cnt), 0);
        check("arst.byte_cnt", int'(byte_cnt), 0);
        enable_timer = 1'b0;
        #2;
        n_rst = 1'b1;
        tick();
        check("arst_rel.busy", int'(busy), 0);
        check("arst_rel.shift_enable", int'(shift_enable), 0);

        // 300 bytes: byte_cnt saturates, pulses continue.
        go_idle();
        start_run();
        br_seen = 0;
        for (int k = 1; k <= 300; k++) begin
            c(64 * k - 4, 0, 1, 0, (k > 255) ? 255 : k, 1);
            c(64 * k - 3, 0, 0, 0, (k > 255) ? 255 : k, 1);
        end
        run_until(64 * 300 - 3);
        check("sat.br_pulses", br_seen, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
